// File: rtl/booth_mult_seq_pkg.sv
// Shared types and the radix-4 Booth recoder for the sequential multiplier.
package booth_pkg;

    // One signed Booth digit: bit2 selects 2a, bit1 selects a, bit0 negates.
    typedef struct packed {
        logic two;
        logic one;
        logic neg;
    } sdn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam sdn_t SDN_ZERO = '{two: 1'b0, one: 1'b0, neg: 1'b0};

    // Recode {b[2i+1], b[2i], b[2i-1]} into a digit in {-2,-1,0,+1,+2}.
    // The all-ones triple is a zero digit, so neg stays clear on it.
    function automatic sdn_t booth_recode(input logic [2:0] triple);
        sdn_t d;
        case (triple)
            3'b000:  d = SDN_ZERO;
            3'b001:  d = '{two: 1'b0, one: 1'b1, neg: 1'b0};
            3'b010:  d = '{two: 1'b0, one: 1'b1, neg: 1'b0};
            3'b011:  d = '{two: 1'b1, one: 1'b0, neg: 1'b0};
            3'b100:  d = '{two: 1'b1, one: 1'b0, neg: 1'b1};
            3'b101:  d = '{two: 1'b0, one: 1'b1, neg: 1'b1};
            3'b110:  d = '{two: 1'b0, one: 1'b1, neg: 1'b1};
            3'b111:  d = SDN_ZERO;
            default: d = SDN_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle between the divider scheduler and the multiplier.
interface booth_mult_seq_if
    import booth_pkg::*;
#(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
    sdn_t             dbg_sdn;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, dbg_sdn
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, dbg_sdn
    );
endinterface

// File: rtl/booth_mult_seq_pp_gen.sv
// Partial-product generator: selects 0/+a/+2a/-a/-2a as a W+2-bit signed value.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  sdn_t           sdn_i,
    input  logic [W-1:0]   a_i,
    output logic [W+1:0]   pp_o
);
    logic [W+1:0] a_ext_s;
    logic [W+1:0] mag_s;

    assign a_ext_s = {{2{a_i[W-1]}}, a_i};

    // Magnitude select then two's-complement negate; W+2 bits hold +-2a without loss.
    always_comb begin
        mag_s = '0;
        pp_o  = '0;
        if (sdn_i.two) begin
            mag_s = {a_ext_s[W:0], 1'b0};
        end else if (sdn_i.one) begin
            mag_s = a_ext_s;
        end else begin
            mag_s = '0;
        end
        if (sdn_i.neg) begin
            pp_o = ~mag_s + {{(W+1){1'b0}}, 1'b1};
        end else begin
            pp_o = mag_s;
        end
    end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-4 Booth multiplier: one digit per cycle into a 2W-bit accumulator.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    booth_mult_seq_if.slave    bus
);
    localparam int NDIG = W / 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [W:0]      b_ext_s;
    logic [CW:0]     bit_idx_s;
    logic [2:0]      triple_s;
    sdn_t            sdn_s;
    logic [W+1:0]    pp_s;
    logic [2*W-1:0]  pp_shift_s;
    logic [2*W-1:0]  acc_sum_s;

    // Digit cnt uses b[2cnt+1:2cnt-1]; the appended zero supplies b[-1].
    assign b_ext_s   = {b_q, 1'b0};
    assign bit_idx_s = {cnt_q, 1'b0};
    assign triple_s  = b_ext_s[bit_idx_s +: 3];
    assign sdn_s     = booth_recode(triple_s);

    booth_pp_gen #(.W(W)) u_pp_gen (
        .sdn_i (sdn_s),
        .a_i   (a_q),
        .pp_o  (pp_s)
    );

    assign pp_shift_s = {{(W-2){pp_s[W+1]}}, pp_s} << bit_idx_s;
    assign acc_sum_s  = acc_q + pp_shift_s;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = prod_q;
    assign bus.dbg_sdn   = (state_q == RUN) ? sdn_s : SDN_ZERO;

    // Next-state, operand capture and accumulation; clear overrides every handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    acc_d = acc_sum_s;
                    if (cnt_q == CW'(NDIG - 1)) begin
                        prod_d  = acc_sum_s;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (W=8): directed vectors plus a short random batch.
module tb_booth_mult_seq;
    logic clk;
    logic rst;
    logic clear;
    int   total;
    int   bad;
    logic [15:0] exp_q[$];

    booth_mult_seq_if #(.W(8)) bif ();

    booth_mult_seq #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Hand-written recode table applied to the bench's own copy of b.
    function automatic logic [2:0] exp_sdn(input logic [7:0] bv, input int k);
        logic [8:0] be;
        logic [2:0] t;
        be = {bv, 1'b0};
        t  = {be[2*k+2], be[2*k+1], be[2*k]};
        case (t)
            3'b001, 3'b010: return 3'b010;
            3'b011:         return 3'b100;
            3'b100:         return 3'b101;
            3'b101, 3'b110: return 3'b011;
            default:        return 3'b000;
        endcase
    endfunction

    // Product monitor: pops the scoreboard on each completed output handshake.
    always @(negedge clk) begin
        if (!rst && bif.out_valid && bif.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_product: got 0x%0h expected none", bif.product);
            end else begin
                check("product", 32'(bif.product), 32'(exp_q.pop_front()));
            end
        end
    end

    // One multiply: accept, check digits and latency, optional backpressure hold.
    task automatic mult(input logic [7:0] av, input logic [7:0] bv, input int hold);
        int ai, bi, p;
        logic [15:0] e;
        ai = $signed(av);
        bi = $signed(bv);
        p  = ai * bi;
        e  = p[15:0];
        @(negedge clk);
        check("in_ready_idle", 32'(bif.in_ready), 32'd1);
        bif.out_ready = (hold == 0) ? 1'b1 : 1'b0;
        bif.in_valid  = 1'b1;
        bif.a         = av;
        bif.b         = bv;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("dbg_sdn", 32'(bif.dbg_sdn), 32'(exp_sdn(bv, k)));
            check("busy_no_valid", 32'({bif.out_valid, bif.in_ready}), 32'd0);
            @(posedge clk);
        end
        #1 check("latency_valid", 32'(bif.out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(bif.out_valid), 32'd1);
            check("hold_product", 32'(bif.product), 32'(e));
            check("hold_in_ready", 32'(bif.in_ready), 32'd0);
            check("hold_sdn", 32'(bif.dbg_sdn), 32'd0);
            bif.in_valid = h[0];
            bif.a        = 8'd1;
            bif.b        = 8'd1;
        end
        if (hold != 0) begin
            @(negedge clk);
            bif.in_valid  = 1'b0;
            bif.out_ready = 1'b1;
        end
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (bif.in_ready) break;
            if (w == 19) check("return_idle_timeout", 32'(bif.in_ready), 32'd1);
        end
    endtask

    // Accept a pair that is later aborted; nothing is pushed to the scoreboard.
    task automatic start_only(input logic [7:0] av, input logic [7:0] bv, input int run_edges);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.a        = av;
        bif.b        = bv;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        repeat (run_edges) @(posedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear = 1'b0;
        bif.in_valid  = 1'b0;
        bif.a         = 8'd0;
        bif.b         = 8'd0;
        bif.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(bif.in_ready), 32'd1);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_product", 32'(bif.product), 32'd0);
        check("rst_sdn", 32'(bif.dbg_sdn), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 7*-3: digits +a (010) then -a (011) then zeros -> -21
        mult(8'd7, 8'hFD, 0);
        mult(8'h80, 8'h80, 0);
        mult(8'd127, 8'd127, 0);
        mult(8'h55, 8'd0, 0);
        mult(8'hFF, 8'hFF, 0);
        mult(8'h80, 8'd127, 0);
        mult(8'd19, 8'hAA, 10);

        // clear on the second RUN cycle, then a fresh 3*5
        start_only(8'd9, 8'd9, 1);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clear_in_ready", 32'(bif.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("clear_no_valid", 32'(bif.out_valid), 32'd0);
        end
        // clear beats a simultaneous accept in IDLE
        bif.in_valid = 1'b1;
        bif.a        = 8'd2;
        bif.b        = 8'd2;
        clear        = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        bif.in_valid = 1'b0;
        check("clear_beats_accept", 32'({bif.in_ready, bif.dbg_sdn}), 32'h8);
        mult(8'd3, 8'd5, 0);

        // async reset mid-RUN
        start_only(8'd100, 8'd50, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(bif.in_ready), 32'd1);
        check("arst_out_valid", 32'(bif.out_valid), 32'd0);
        check("arst_product", 32'(bif.product), 32'd0);
        check("arst_sdn", 32'(bif.dbg_sdn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mult(8'd6, 8'hF9, 0);

        for (int r = 0; r < 100; r++) begin
            mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
